// File: rtl/cla_serial_add_arbiter.sv
// Round-robin sequencer that shares one external 4-bit CLA adder between two
// requesters, adding WIDTH-bit operands one nibble per cycle, LSB first.
module cla_serial_add_arbiter #(
  parameter int NIBBLES = 4,
  localparam int WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [3:0]       adder_a,
  output logic [3:0]       adder_b,
  output logic             adder_cin,
  input  logic [3:0]       adder_sum,
  input  logic             adder_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_id
);

  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [KW-1:0]    k_r;
  logic [KW+1:0]    bit_base_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_nxt_s;
  logic [WIDTH-1:0] res_sum_r;
  logic             cin_r;
  logic             carry_r;
  logic             id_r;
  logic             last_grant_r;
  logic             res_valid_r;
  logic             res_cout_r;
  logic             res_ovf_r;
  logic             res_id_r;
  logic             grant0_s;
  logic             grant1_s;
  logic             accept_s;
  logic             last_nib_s;

  assign bit_base_s = {k_r, 2'b00};
  assign last_nib_s = (k_r == KW'(NIBBLES - 1));
  assign accept_s   = grant0_s | grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  assign res_valid  = res_valid_r;
  assign res_sum    = res_sum_r;
  assign res_cout   = res_cout_r;
  assign res_ovf    = res_ovf_r;
  assign res_id     = res_id_r;

  // Round-robin grant: on a tie, favour the requester not served last time.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_r == IDLE) && !rst) begin
      grant1_s = req1_valid && (!req0_valid || !last_grant_r);
      grant0_s = req0_valid && !grant1_s;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_nib_s) state_nxt_s = DONE;
        else            state_nxt_s = RUN;
      end
      DONE: begin
        if (res_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Shared adder is driven only while running; carry comes from the operand on nibble 0.
  always_comb begin
    adder_a   = 4'd0;
    adder_b   = 4'd0;
    adder_cin = 1'b0;
    if (state_r == RUN) begin
      adder_a   = a_r[bit_base_s +: 4];
      adder_b   = b_r[bit_base_s +: 4];
      adder_cin = (k_r == {KW{1'b0}}) ? cin_r : carry_r;
    end else begin
      adder_a   = 4'd0;
      adder_b   = 4'd0;
      adder_cin = 1'b0;
    end
  end

  // Working sum with the current nibble merged in.
  always_comb begin
    sum_nxt_s = sum_r;
    sum_nxt_s[bit_base_s +: 4] = adder_sum;
  end

  // Operand capture, nibble stepping and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      sum_r        <= {WIDTH{1'b0}};
      cin_r        <= 1'b0;
      carry_r      <= 1'b0;
      id_r         <= 1'b0;
      k_r          <= {KW{1'b0}};
      last_grant_r <= 1'b1;
      res_valid_r  <= 1'b0;
      res_sum_r    <= {WIDTH{1'b0}};
      res_cout_r   <= 1'b0;
      res_ovf_r    <= 1'b0;
      res_id_r     <= 1'b0;
    end else if (accept_s) begin
      a_r          <= grant1_s ? req1_a : req0_a;
      b_r          <= grant1_s ? req1_b : req0_b;
      cin_r        <= grant1_s ? req1_cin : req0_cin;
      id_r         <= grant1_s;
      last_grant_r <= grant1_s;
      k_r          <= {KW{1'b0}};
    end else if (state_r == RUN) begin
      sum_r   <= sum_nxt_s;
      carry_r <= adder_cout;
      if (last_nib_s) begin
        res_valid_r <= 1'b1;
        res_sum_r   <= sum_nxt_s;
        res_cout_r  <= adder_cout;
        res_ovf_r   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_nxt_s[WIDTH-1] != a_r[WIDTH-1]);
        res_id_r    <= id_r;
      end else begin
        k_r <= k_r + KW'(1'b1);
      end
    end else if ((state_r == DONE) && res_ready) begin
      res_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_serial_add_arbiter.sv
// Self-checking bench for cla_serial_add_arbiter: directed and random additions
// against an integer reference model, plus arbitration, backpressure and reset cases.
module tb_cla_serial_add_arbiter;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic [3:0]   adder_a, adder_b, adder_sum;
  logic         adder_cin, adder_cout;
  logic         res_valid, res_cout, res_ovf, res_id;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_sum;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  cla_serial_add_arbiter #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_ovf(res_ovf), .res_id(res_id)
  );

  // The shared external 4-bit adder.
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {4'd0, adder_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: unsigned sum/carry from integer addition, overflow from signed range.
  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                  output logic [W-1:0] s, output logic co, output logic ov);
    longint ua, ub, us, sa, sb, ss;
    ua = longint'(a);
    ub = longint'(b);
    us = ua + ub + longint'(cin);
    s  = us[W-1:0];
    co = ((us >> W) & 64'sd1) != 0;
    sa = a[W-1] ? ua - (64'sd1 <<< W) : ua;
    sb = b[W-1] ? ub - (64'sd1 <<< W) : ub;
    ss = sa + sb + longint'(cin);
    ov = (ss > ((64'sd1 <<< (W - 1)) - 1)) || (ss < -(64'sd1 <<< (W - 1)));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one request and waits for its accept; returns the accept cycle.
  task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      output int acc);
    logic got;
    got = 1'b0;
    acc = 0;
    if (id == 0) begin req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1; end
    else         begin req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1; end
    #1;
    for (int i = 0; i < 40; i++) begin
      if ((id == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        acc = cyc;
        break;
      end
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL accept_timeout: req%0d ready never seen, required within 40 cycles", id);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Waits for the result, checks latency and contents, then consumes it.
  task automatic collect(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input int acc);
    logic [W-1:0] es;
    logic eco, eov, got;
    ref_add(a, b, cin, es, eco, eov);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (res_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL result_timeout: res_valid never rose for req%0d", id);
    end
    n_cmp++;
    if ((cyc - acc) !== (N + 1)) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles, required %0d", cyc - acc, N + 1);
    end
    n_cmp++;
    if ({res_sum, res_cout, res_ovf, res_id} !== {es, eco, eov, 1'(id)}) begin
      n_bad++;
      $display("FAIL result a=%h b=%h cin=%b: got sum=%h cout=%b ovf=%b id=%b, required sum=%h cout=%b ovf=%b id=%0d",
               a, b, cin, res_sum, res_cout, res_ovf, res_id, es, eco, eov, id);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL res_valid_drop: got %b, required 0", res_valid);
    end
  endtask

  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int acc;
    send(id, a, b, cin, acc);
    collect(id, a, b, cin, acc);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL ready_in_reset: got %b%b, required 00", req0_ready, req1_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({res_valid, res_sum, res_cout, res_ovf, res_id, adder_a, adder_b, adder_cin} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got valid=%b sum=%h cout=%b ovf=%b id=%b adder=%h/%h/%b, required all 0",
               res_valid, res_sum, res_cout, res_ovf, res_id, adder_a, adder_b, adder_cin);
    end
  endtask

  task automatic test_directed();
    run_op(0, 16'h1234, 16'h0FFF, 1'b0);
    run_op(1, 16'hFFFF, 16'h0000, 1'b1);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0);
    run_op(1, 16'h8000, 16'h8000, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_op(int'($urandom_range(1, 0)), W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa [2];
    logic [W-1:0] ob [2];
    logic         oc [2];
    int           q_id [$];
    logic [W-1:0] q_sum [$];
    logic         q_co [$];
    int           model_last, g, done_cnt, exp_id;
    logic [W-1:0] es;
    logic eco, eov;
    do_reset();
    model_last = 1;
    done_cnt = 0;
    for (int r = 0; r < 2; r++) begin
      oa[r] = W'($urandom); ob[r] = W'($urandom); oc[r] = 1'($urandom);
    end
    req0_a = oa[0]; req0_b = ob[0]; req0_cin = oc[0];
    req1_a = oa[1]; req1_b = ob[1]; req1_cin = oc[1];
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 200 && done_cnt < 4; c++) begin
      #1;
      g = -1;
      n_cmp++;
      if (req0_ready && req1_ready) begin
        n_bad++;
        $display("FAIL ready_exclusive: both readies high in cycle %0d", cyc);
      end
      if (req0_ready || req1_ready) begin
        g = req1_ready ? 1 : 0;
        exp_id = 1 - model_last;
        n_cmp++;
        if (g !== exp_id) begin
          n_bad++;
          $display("FAIL grant_order: got req%0d, required req%0d", g, exp_id);
        end
        model_last = g;
        ref_add(oa[g], ob[g], oc[g], es, eco, eov);
        q_id.push_back(g);
        q_sum.push_back(es);
        q_co.push_back(eco);
      end
      if (res_valid) begin
        done_cnt++;
        n_cmp++;
        if (q_id.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_unexpected: result id=%b with nothing outstanding", res_id);
        end else begin
          exp_id = q_id.pop_front();
          es = q_sum.pop_front();
          eco = q_co.pop_front();
          if ({res_id, res_sum, res_cout} !== {1'(exp_id), es, eco}) begin
            n_bad++;
            $display("FAIL b2b_result: got id=%b sum=%h cout=%b, required id=%0d sum=%h cout=%b",
                     res_id, res_sum, res_cout, exp_id, es, eco);
          end
        end
        if (done_cnt == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      if (g >= 0) begin
        oa[g] = W'($urandom); ob[g] = W'($urandom); oc[g] = 1'($urandom);
        if (g == 0) begin req0_a = oa[0]; req0_b = ob[0]; req0_cin = oc[0]; end
        else        begin req1_a = oa[1]; req1_b = ob[1]; req1_cin = oc[1]; end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (done_cnt != 4) begin
      n_bad++;
      $display("FAIL b2b_timeout: got %0d results, required 4", done_cnt);
    end
    res_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, es, a1, b1;
    logic cin, eco, eov, got;
    int acc;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    ref_add(a, b, cin, es, eco, eov);
    send(0, a, b, cin, acc);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (res_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL bp_timeout: res_valid never rose");
    end
    a1 = W'($urandom); b1 = W'($urandom);
    req1_a = a1; req1_b = b1; req1_cin = 1'b0; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if ({res_valid, res_sum, res_cout, res_ovf, res_id, req0_ready, req1_ready, adder_a, adder_b, adder_cin}
          !== {1'b1, es, eco, eov, 1'b0, 2'b00, 9'd0}) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d: got valid=%b sum=%h cout=%b ovf=%b id=%b rdy=%b%b adder=%h/%h/%b, required 1 %h %b %b 0 00 0/0/0",
                 i, res_valid, res_sum, res_cout, res_ovf, res_id, req0_ready, req1_ready,
                 adder_a, adder_b, adder_cin, es, eco, eov);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    n_cmp++;
    if ({res_valid, req1_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_release: got valid=%b req1_ready=%b, required 0 and 1", res_valid, req1_ready);
    end
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    collect(1, a1, b1, 1'b0, acc);
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] a, b;
    int acc;
    send(1, W'($urandom), W'($urandom), 1'b1, acc);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({res_valid, adder_a, adder_b, adder_cin} !== 10'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got valid=%b adder=%h/%h/%b, required all 0", res_valid, adder_a, adder_b, adder_cin);
    end
    a = W'($urandom); b = W'($urandom);
    req0_a = a; req0_b = b; req0_cin = 1'b0;
    req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL tie_after_reset: got ready=%b%b, required 10", req0_ready, req1_ready);
    end
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    collect(0, a, b, 1'b0, acc);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_serial_add_arbiter.md
# cla_serial_add_arbiter

Sequencer and arbiter that shares one external 4-bit carry-look-ahead adder between two requesters. It performs WIDTH-bit additions nibble-serially: one nibble per cycle, least significant first, with the carry chained through a register. Each result is returned on a valid/ready result port tagged with the requester ID. It sits between the arithmetic clients and the single shared 4-bit CLA adder instance.

## Interface
- NIBBLES, default 4: operand width in nibbles. WIDTH = 4*NIBBLES (16 by default). Legal range 1..16.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- adder_a, adder_b  out  4  nibble driven to the shared adder.
- adder_cin  out  1  carry driven to the shared adder.
- adder_sum  in  4  combinational sum from the shared adder.
- adder_cout  in  1  combinational carry-out from the shared adder.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  WIDTH  sum.
- res_cout  out  1  unsigned carry-out of bit WIDTH-1.
- res_ovf  out  1  signed two's-complement overflow.
- res_id  out  1  requester that issued the operation.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE, arbitration:**
  - Round-robin. If only one valid is high, that requester is granted.
  - If both are high, the requester that was not granted last is granted.
  - last_grant resets to 1, so req0 wins the first tie.
- **IDLE, accept:**
  - reqN_ready = (state==IDLE) and granted N. This is combinational from the valids.
  - Only one ready is ever high in a cycle.
  - On valid&ready: latch a, b, cin and id; set last_grant=id; clear nibble index k=0; go to RUN.
- **RUN, per cycle:**
  - Drive adder_a = a[4k+3:4k] and adder_b = b[4k+3:4k].
  - adder_cin = latched cin when k=0, otherwise the carry register.
  - At the clock edge: sum[4k+3:4k] <= adder_sum; carry <= adder_cout; k <= k+1.
  - On the cycle with k = NIBBLES-1, go to DONE instead of incrementing.
- **DONE:**
  - res_valid=1. res_sum, res_cout (final carry) and res_id are held stable.
  - res_ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
  - Stays in DONE until res_ready=1, then goes to IDLE.
  - No new request is accepted in DONE.
- **Drive rules:**
  - adder_a, adder_b and adder_cin are 0 outside RUN.
  - res_* data outputs hold their last value outside DONE. They are only meaningful while res_valid=1.
- **Request rules:**
  - Requester operands must stay stable while valid=1 and ready=0.
  - The block samples operands only on the accept edge.

## Timing
- Reset values:
  - state=IDLE, last_grant=1, k=0, carry=0.
  - res_valid=0, res_sum=0, res_cout=0, res_ovf=0, res_id=0.
  - adder_* = 0.
  - req0_ready and req1_ready are 0 during the rst=1 cycle.
- Latency:
  - Accept at edge t.
  - RUN occupies cycles t+1 .. t+NIBBLES.
  - res_valid rises at cycle t+NIBBLES+1.
- Throughput:
  - With res_ready held high, one operation completes every NIBBLES+2 cycles (accept, NIBBLES RUN cycles, DONE).
  - The next accept happens in the IDLE cycle after DONE.
- Backpressure: res_ready low holds DONE and all res_* outputs indefinitely.
- Reset mid-operation (rst=1 in RUN or DONE):
  - Next state is IDLE and the in-flight operation is discarded.
  - res_valid=0 in the following cycle.
  - The requester is not re-served unless it re-asserts valid.
- Simultaneous events:
  - A requester dropping valid in the same cycle it is granted is a protocol violation. The design does not need to handle it.
  - res_ready high outside DONE is ignored.
- NIBBLES=1: RUN lasts exactly one cycle.

## Test plan
- req0 only: a=0x1234, b=0x0FFF, cin=0. Expect res_sum=0x2233, cout=0, ovf=0, id=0, and res_valid exactly 5 cycles after accept.
- req1 only: a=0xFFFF, b=0x0000, cin=1. Expect sum=0x0000, cout=1, ovf=0, id=1. Ripple-through carry across all 4 nibbles.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0. Expect sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000. Expect sum=0x0000, cout=1, ovf=1.
- Both valid continuously with distinct operands and res_ready=1. Expect grant order 0,1,0,1, res_id alternating, and ready never high on both requesters in any cycle.
- Backpressure: hold res_ready=0 for 10 cycles in DONE. Expect res_* stable, no req ready asserted, and adder_* = 0. Release, then expect IDLE on the next cycle.
- Reset asserted in the 2nd RUN cycle. Expect res_valid=0, adder_*=0 and last_grant=1 afterward. A subsequent tie grants req0, and the operation completes with a correct sum.
